h_bridge_status_pio: RTL and testbench

//  Avalon-MM slave input port: reads H-bridge status/fault lines into the Nios II system.

---
 rtl/h_bridge_status_pio_if.sv | 20 ++
 rtl/h_bridge_status_pio.sv | 86 ++++++++
 tb/tb_h_bridge_status_pio.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/h_bridge_status_pio_if.sv
// Avalon-MM slave bus bundle for the H-bridge status input port.
// The master drives address and write strobes; the slave returns read data and irq.
interface h_bridge_status_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/h_bridge_status_pio.sv
// H-bridge status input port: per-bit 2-flop sync, debounce, sticky edge capture,
// and a maskable level interrupt, read over an Avalon-MM slave.
module h_bridge_status_pio #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_TYPE       = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  h_bridge_status_pio_if.slave   bus,
  input  logic [WIDTH-1:0]       in_port
);

  // A one-cycle filter still needs a 1-bit counter so the compare below stays legal.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_1;
  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_nxt;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] clr_mask;
  logic [CNT_W-1:0] cnt     [WIDTH];
  logic [CNT_W-1:0] cnt_nxt [WIDTH];
  logic             wr;
  logic             unused_wdata;

  assign wr           = bus.chipselect & ~bus.write_n;
  assign unused_wdata = ^bus.writedata;

  always_comb begin
    deb_nxt = deb;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = '0;
      if (sync_s[i] != deb[i]) begin
        if (cnt[i] == CNT_LAST) deb_nxt[i] = sync_s[i];
        else                    cnt_nxt[i] = cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_set = deb_nxt & ~deb;
      1:       edge_set = ~deb_nxt & deb;
      default: edge_set = deb_nxt ^ deb;
    endcase
  end

  assign clr_mask = (wr && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1      <= '0;
      sync_s      <= '0;
      deb         <= '0;
      cnt         <= '{default: '0};
      irqmask     <= '0;
      edgecapture <= '0;
    end else begin
      sync_1 <= in_port;
      sync_s <= sync_1;
      deb    <= deb_nxt;
      cnt    <= cnt_nxt;
      if (wr && bus.address == 2'd2) irqmask <= bus.writedata[WIDTH-1:0];
      // A new edge in the same cycle as its clear keeps the bit set.
      edgecapture <= (edgecapture & ~clr_mask) | edge_set;
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      2'd0:    bus.readdata[WIDTH-1:0] = deb;
      2'd2:    bus.readdata[WIDTH-1:0] = irqmask;
      2'd3:    bus.readdata[WIDTH-1:0] = edgecapture;
      default: bus.readdata = '0;
    endcase
  end

  assign bus.irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_h_bridge_status_pio.sv
// Directed bench: three builds (rising, falling, any edge) share one bus and input,
// expectations are queued per step and popped when the DUT output is sampled.
module tb_h_bridge_status_pio;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [2:0]  in_port;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    bit          is_irq;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] e2;
  } sb_t;

  sb_t sb_q[$];

  h_bridge_status_pio_if bus0 ();
  h_bridge_status_pio_if bus1 ();
  h_bridge_status_pio_if bus2 ();

  assign bus0.address = address;  assign bus1.address = address;  assign bus2.address = address;
  assign bus0.chipselect = chipselect; assign bus1.chipselect = chipselect; assign bus2.chipselect = chipselect;
  assign bus0.write_n = write_n;  assign bus1.write_n = write_n;  assign bus2.write_n = write_n;
  assign bus0.writedata = writedata; assign bus1.writedata = writedata; assign bus2.writedata = writedata;

  h_bridge_status_pio #(.WIDTH(3), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) dut_rise (
    .clk(clk), .reset(reset), .bus(bus0.slave), .in_port(in_port));
  h_bridge_status_pio #(.WIDTH(3), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) dut_fall (
    .clk(clk), .reset(reset), .bus(bus1.slave), .in_port(in_port));
  h_bridge_status_pio #(.WIDTH(3), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) dut_any (
    .clk(clk), .reset(reset), .bus(bus2.slave), .in_port(in_port));

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic compare_pop();
    sb_t s;
    s = sb_q.pop_front();
    if (s.is_irq) begin
      cmp({s.tag, "/rise"}, {31'b0, bus0.irq}, s.e0);
      cmp({s.tag, "/fall"}, {31'b0, bus1.irq}, s.e1);
      cmp({s.tag, "/any"},  {31'b0, bus2.irq}, s.e2);
    end else begin
      cmp({s.tag, "/rise"}, bus0.readdata, s.e0);
      cmp({s.tag, "/fall"}, bus1.readdata, s.e1);
      cmp({s.tag, "/any"},  bus2.readdata, s.e2);
    end
  endtask

  task automatic check_read(input logic [1:0] a, input logic [31:0] x0, input logic [31:0] x1,
                            input logic [31:0] x2, input string tag);
    sb_t s;
    s.tag = tag; s.is_irq = 1'b0; s.e0 = x0; s.e1 = x1; s.e2 = x2;
    sb_q.push_back(s);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    compare_pop();
    chipselect = 1'b0;
  endtask

  task automatic check_irq(input logic i0, input logic i1, input logic i2, input string tag);
    sb_t s;
    s.tag = tag; s.is_irq = 1'b1;
    s.e0 = {31'b0, i0}; s.e1 = {31'b0, i1}; s.e2 = {31'b0, i2};
    sb_q.push_back(s);
    #1;
    compare_pop();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 3'b111;

    // Reset held with all inputs high: everything reads 0, across several cycles.
    tick(3);
    check_read(2'd0, 0, 0, 0, "rst_a0");
    check_read(2'd1, 0, 0, 0, "rst_a1");
    check_read(2'd2, 0, 0, 0, "rst_a2");
    check_irq(0, 0, 0, "rst_irq");
    tick(6);
    check_read(2'd0, 0, 0, 0, "rst_hold_a0");
    check_read(2'd3, 0, 0, 0, "rst_hold_a3");
    in_port = 3'b000;
    tick(3);
    reset = 1'b0;
    tick(3);

    // Latency: change sampled at edge k reaches d at edge k+5.
    in_port = 3'b001;
    tick(5);
    check_read(2'd0, 0, 0, 0, "lat_before");
    tick(1);
    check_read(2'd0, 1, 1, 1, "lat_at");
    check_read(2'd3, 1, 0, 1, "lat_edge");
    bus_write(2'd3, 32'h7);
    check_read(2'd3, 0, 0, 0, "lat_clr");

    // Three-cycle glitch on bit 1 is rejected.
    in_port = 3'b011;
    tick(3);
    in_port = 3'b001;
    tick(10);
    check_read(2'd0, 1, 1, 1, "glitch_d");
    check_read(2'd3, 0, 0, 0, "glitch_edge");

    // Mask register: upper bits dropped, then irq on bit 2.
    bus_write(2'd2, 32'hFFFF_FFFF);
    check_read(2'd2, 7, 7, 7, "mask_wide");
    bus_write(2'd2, 32'h4);
    check_read(2'd2, 4, 4, 4, "mask_rd");
    check_irq(0, 0, 0, "irq_idle");
    in_port = 3'b101;
    tick(5);
    check_irq(0, 0, 0, "irq_before");
    tick(1);
    check_irq(1, 0, 1, "irq_set");
    check_read(2'd3, 4, 0, 4, "irq_edge");
    bus_write(2'd3, 32'h4);
    check_irq(0, 0, 0, "irq_clr");
    check_read(2'd3, 0, 0, 0, "irq_edge_clr");
    bus_write(2'd0, 32'h0);
    check_read(2'd0, 5, 5, 5, "a0_wr_ignored");
    bus_write(2'd1, 32'h7);
    check_read(2'd1, 0, 0, 0, "a1_reserved");

    // Falling edge on bit 0: only the falling and any-edge builds capture it.
    in_port = 3'b100;
    tick(8);
    check_read(2'd0, 4, 4, 4, "fall_d");
    check_read(2'd3, 0, 1, 1, "fall_edge");
    check_irq(0, 0, 0, "fall_irq_masked");
    bus_write(2'd3, 32'h7);
    check_read(2'd3, 0, 0, 0, "fall_clr");

    // Clear write lands on the same edge that d[0] rises: set wins.
    in_port = 3'b101;
    tick(5);
    bus_write(2'd3, 32'h1);
    check_read(2'd0, 5, 5, 5, "race_d");
    check_read(2'd3, 1, 0, 1, "race_edge");
    bus_write(2'd2, 32'h1);
    check_irq(1, 0, 1, "race_irq");

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
